// File: rtl/word_unpacker.sv
// Block-to-beat unpacker: queues wide plaintext blocks and streams them out as narrow
// AXI-Stream beats with per-block beat counts, selectable beat order and frame tlast.
module word_unpacker #(
    parameter int IN_W      = 128,
    parameter int OUT_W     = 8,
    parameter int DEPTH     = 2,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CW        = $clog2(IN_W / OUT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  plain_block,
    input  logic             load_en,
    input  logic [CW-1:0]    load_count,
    input  logic             load_last,
    output logic             buffer_ready,
    output logic [OUT_W-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic             overflow,
    output logic             busy
);
    localparam int N  = IN_W / OUT_W;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] N_C      = CW'(N);
    localparam logic [OW-1:0] DEPTH_C  = OW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [IN_W-1:0]  blk_q [DEPTH];
    logic [CW-1:0]    cnt_q [DEPTH];
    logic [DEPTH-1:0] last_q;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]    occ_q;
    logic [CW-1:0]    beat_q;
    logic             overflow_q;

    logic             push, pop, hs, final_beat;
    logic [CW-1:0]    eff_count;
    logic [OUT_W-1:0] beat_data;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Zero and oversized counts both mean "the whole block".
    assign eff_count = (load_count == '0 || load_count > N_C) ? N_C : load_count;

    assign buffer_ready  = !reset && (occ_q < DEPTH_C);
    assign push          = load_en && buffer_ready;
    assign m_axis_tvalid = (occ_q != '0);
    assign busy          = m_axis_tvalid;
    assign hs            = m_axis_tvalid && m_axis_tready;
    assign final_beat    = (beat_q == cnt_q[rd_ptr_q] - CW'(1));
    assign pop           = hs && final_beat;

    always_comb begin
        beat_data = '0;
        for (int i = 0; i < N; i++) begin
            if (beat_q == CW'(i)) begin
                if (MSB_FIRST) begin
                    beat_data = blk_q[rd_ptr_q][IN_W-1-i*OUT_W -: OUT_W];
                end else begin
                    beat_data = blk_q[rd_ptr_q][i*OUT_W +: OUT_W];
                end
            end
        end
    end

    // Data is gated so an empty queue presents all-zero tdata.
    assign m_axis_tdata = m_axis_tvalid ? beat_data : '0;
    assign m_axis_tlast = m_axis_tvalid && last_q[rd_ptr_q] && final_beat;
    assign overflow     = overflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            beat_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (load_en && !buffer_ready) begin
                overflow_q <= 1'b1;
            end
            if (push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (hs) begin
                beat_q <= final_beat ? '0 : beat_q + CW'(1);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (push && !pop) begin
                occ_q <= occ_q + OW'(1);
            end else if (pop && !push) begin
                occ_q <= occ_q - OW'(1);
            end
        end
    end

    // Slot payload needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            blk_q[wr_ptr_q]  <= plain_block;
            cnt_q[wr_ptr_q]  <= eff_count;
            last_q[wr_ptr_q] <= load_last;
        end
    end
endmodule
